// File: rtl/spi_arb_pkg.sv
// Shared types and sizing helpers for the SPI transfer arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEFAULT_NUM_REQ = 4;
  localparam int unsigned GRANT_W         = grant_w(DEFAULT_NUM_REQ);

endpackage

// File: rtl/spi_xfer_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_W   = GRANT_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  // Scan from the pointer position and keep the first active request.
  always_comb begin
    int unsigned idx;
    logic [IDX_W-1:0] sel;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      sel = IDX_W'(idx);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one word-level SPI engine between NUM_REQ chip-select owners, one whole
// transaction per grant, with CS setup/hold/gap framing.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_GAP     = 4
) (
  input  logic                            clk_i,
  input  logic                            arstn_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
  output logic [NUM_REQ-1:0]              req_ack_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_tdata_i,
  input  logic [NUM_REQ-1:0]              req_tvalid_i,
  output logic [NUM_REQ-1:0]              req_tready_o,
  output logic [DATA_WIDTH-1:0]           rsp_tdata_o,
  output logic [NUM_REQ-1:0]              rsp_tvalid_o,
  output logic                            rsp_tlast_o,
  input  logic [NUM_REQ-1:0]              rsp_tready_i,
  output logic [DATA_WIDTH-1:0]           eng_tx_tdata_o,
  output logic                            eng_tx_tvalid_o,
  input  logic                            eng_tx_tready_i,
  input  logic [DATA_WIDTH-1:0]           eng_rx_tdata_i,
  input  logic                            eng_rx_tvalid_i,
  output logic                            eng_rx_tready_o,
  output logic [NUM_REQ-1:0]              spi_cs_n_o,
  output logic                            busy_o,
  output logic [$clog2(NUM_REQ)-1:0]      grant_o
);

  localparam int unsigned IDX_W   = grant_w(NUM_REQ);
  localparam int unsigned SH_MAX  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned TMR_MAX = (SH_MAX > CS_GAP) ? SH_MAX : CS_GAP;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CS_HOLD - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(CS_GAP - 1);

  state_t               state, state_d;
  logic [IDX_W-1:0]     grant, ptr, pick_idx;
  logic [NUM_REQ-1:0]   pick_oh, cs_n, ack;
  logic                 pick_any;
  logic [LEN_WIDTH:0]   len, tx_cnt, rx_cnt;
  logic [TMR_W-1:0]     tmr;
  logic                 slot_open, tx_hs, rx_hs, rx_last, do_grant;
  logic                 spurious_seen;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid_i),
    .ptr     (ptr),
    .gnt     (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Next-state decode plus stream steering toward the granted requester.
  always_comb begin
    state_d         = state;
    do_grant        = 1'b0;
    tx_hs           = 1'b0;
    rx_hs           = 1'b0;
    slot_open       = (tx_cnt == rx_cnt) && (tx_cnt <= len);
    rx_last         = (rx_cnt == len);
    req_tready_o    = '0;
    rsp_tvalid_o    = '0;
    rsp_tlast_o     = 1'b0;
    eng_tx_tvalid_o = 1'b0;
    eng_rx_tready_o = 1'b1;
    eng_tx_tdata_o  = req_tdata_i[grant*DATA_WIDTH +: DATA_WIDTH];
    rsp_tdata_o     = eng_rx_tdata_i;
    case (state)
      IDLE: begin
        if (pick_any) begin
          do_grant = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (tmr == SETUP_LAST) state_d = XFER;
      end
      XFER: begin
        req_tready_o[grant] = slot_open && eng_tx_tready_i;
        eng_tx_tvalid_o     = slot_open && req_tvalid_i[grant];
        rsp_tvalid_o[grant] = eng_rx_tvalid_i;
        eng_rx_tready_o     = rsp_tready_i[grant];
        rsp_tlast_o         = rx_last;
        tx_hs = slot_open && req_tvalid_i[grant] && eng_tx_tready_i;
        rx_hs = eng_rx_tvalid_i && rsp_tready_i[grant];
        if (rx_hs && rx_last) state_d = HOLD;
      end
      HOLD: begin
        if (tmr == HOLD_LAST) state_d = GAP;
      end
      GAP: begin
        if (tmr == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) state <= IDLE;
    else          state <= state_d;
  end

  // Grant latch, word counters, phase timer and registered chip selects.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      grant         <= '0;
      ptr           <= '0;
      len           <= '0;
      tx_cnt        <= '0;
      rx_cnt        <= '0;
      tmr           <= '0;
      cs_n          <= '1;
      ack           <= '0;
      spurious_seen <= 1'b0;
    end else begin
      ack <= '0;
      tmr <= (state_d != state) ? '0 : tmr + 1'b1;
      if (do_grant) begin
        grant  <= pick_idx;
        ptr    <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        len    <= {1'b0, req_len_i[pick_idx*LEN_WIDTH +: LEN_WIDTH]};
        tx_cnt <= '0;
        rx_cnt <= '0;
        cs_n   <= ~pick_oh;
        ack    <= pick_oh;
      end
      if (tx_hs) tx_cnt <= tx_cnt + 1'b1;
      if (rx_hs) rx_cnt <= rx_cnt + 1'b1;
      if (state == HOLD && state_d == GAP) cs_n <= '1;
      if (state != XFER && eng_rx_tvalid_i) spurious_seen <= 1'b1;
    end
  end

  assign spi_cs_n_o = cs_n;
  assign req_ack_o  = ack;
  assign busy_o     = (state != IDLE);
  assign grant_o    = grant;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter; the engine model echoes each tx word inverted.
module tb_spi_xfer_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic arstn;
  logic [N-1:0]    req_valid, req_ack, req_tvalid, req_tready;
  logic [N-1:0]    rsp_tvalid, rsp_tready, cs_n, tv_en;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_tdata;
  logic [DW-1:0]   rsp_tdata, eng_tx_tdata, eng_rx_tdata;
  logic            rsp_tlast, eng_tx_tvalid, eng_tx_tready;
  logic            eng_rx_tvalid, eng_rx_tready, busy;
  logic [1:0]      grant;

  logic            eng_vld, eng_busy, spur;
  logic [DW-1:0]   eng_data;
  logic [DW-1:0]   base [N];
  logic [DW-1:0]   sent [N];

  int checks = 0;
  int errors = 0;

  int t_ack, t_tx, t_last, t_cs, t_idle, cs_rises, min_run, stall_cyc, overlap;
  int nongrant_bad = 0;
  int bad_ack = 0;
  logic [N-1:0] cs_at_ack;
  logic [1:0]   ack_log [$];
  logic [DW-1:0] rx_data [$];
  logic         rx_last [$];

  always #5 clk = ~clk;

  spi_xfer_arbiter #(
    .NUM_REQ (N), .DATA_WIDTH (DW), .LEN_WIDTH (LW),
    .CS_SETUP (2), .CS_HOLD (2), .CS_GAP (4)
  ) dut (
    .clk_i (clk), .arstn_i (arstn),
    .req_valid_i (req_valid), .req_len_i (req_len), .req_ack_o (req_ack),
    .req_tdata_i (req_tdata), .req_tvalid_i (req_tvalid), .req_tready_o (req_tready),
    .rsp_tdata_o (rsp_tdata), .rsp_tvalid_o (rsp_tvalid), .rsp_tlast_o (rsp_tlast),
    .rsp_tready_i (rsp_tready),
    .eng_tx_tdata_o (eng_tx_tdata), .eng_tx_tvalid_o (eng_tx_tvalid),
    .eng_tx_tready_i (eng_tx_tready),
    .eng_rx_tdata_i (eng_rx_tdata), .eng_rx_tvalid_i (eng_rx_tvalid),
    .eng_rx_tready_o (eng_rx_tready),
    .spi_cs_n_o (cs_n), .busy_o (busy), .grant_o (grant)
  );

  assign eng_tx_tready = !eng_busy;
  assign eng_rx_tvalid = eng_vld | spur;
  assign eng_rx_tdata  = eng_data;
  assign req_tvalid    = tv_en;

  // Engine model: one word in flight, answers the cycle after accepting tx.
  always @(posedge clk) begin
    if (!arstn) begin
      eng_busy <= 1'b0;
      eng_vld  <= 1'b0;
      eng_data <= '0;
    end else if (!eng_busy && eng_tx_tvalid) begin
      eng_busy <= 1'b1;
      eng_vld  <= 1'b1;
      eng_data <= ~eng_tx_tdata;
    end else if (eng_vld && eng_rx_tready) begin
      eng_busy <= 1'b0;
      eng_vld  <= 1'b0;
    end
  end

  // Requester sources: word n of a transaction is base + n.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!arstn || req_ack[i]) sent[i] <= '0;
      else if (req_tvalid[i] && req_tready[i]) sent[i] <= sent[i] + 1'b1;
    end
  end

  // Per-lane tx data presented to the arbiter.
  always_comb begin
    req_tdata = '0;
    for (int i = 0; i < N; i++) req_tdata[i*DW +: DW] = base[i] + sent[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs cycles until n_acks grants were seen and the arbiter is idle again,
  // applying optional rx-backpressure and tx-valid gap windows.
  task automatic watch(input int n_acks, input int stall_at, input int stall_len,
                       input int gap_at, input int gap_len, input int max_cyc);
    logic prev_high, all_high, done;
    logic [N-1:0] gmask;
    int run;
    ack_log.delete(); rx_data.delete(); rx_last.delete();
    t_ack = -1; t_tx = -1; t_last = -1; t_cs = -1; t_idle = -1;
    cs_rises = 0; min_run = 999; stall_cyc = 0; overlap = 0;
    prev_high = 1'b1; run = 0; done = 1'b0;
    for (int k = 1; k <= max_cyc && !done; k++) begin
      @(negedge clk);
      rsp_tready = (k >= stall_at && k < stall_at + stall_len) ? '0 : '1;
      tv_en      = (k >= gap_at && k < gap_at + gap_len) ? '0 : '1;
      #1;
      all_high = &cs_n;
      gmask    = 4'b0001 << grant;
      if (|req_ack) begin
        ack_log.push_back(grant);
        if (req_ack != gmask) bad_ack++;
        if (t_ack < 0) begin t_ack = k; cs_at_ack = cs_n; end
        if (ack_log.size() == n_acks) req_valid = '0;
      end
      if (eng_tx_tvalid && t_tx < 0) t_tx = k;
      if (rsp_tvalid[grant] && rsp_tready[grant]) begin
        rx_data.push_back(rsp_tdata);
        rx_last.push_back(rsp_tlast);
        if (rsp_tlast) t_last = k;
      end
      if (((rsp_tvalid | req_tready) & ~gmask) != '0) nongrant_bad++;
      if (!eng_rx_tready) stall_cyc++;
      if (eng_vld && eng_tx_tvalid) overlap++;
      if (!all_high && prev_high && cs_rises > 0 && run < min_run) min_run = run;
      if (all_high && !prev_high) begin cs_rises++; t_cs = k; run = 0; end
      if (all_high) run++;
      prev_high = all_high;
      if (ack_log.size() == n_acks && !busy) begin t_idle = k; done = 1'b1; end
    end
    check("watch_completes", 32'(done), 32'd1);
  endtask

  initial begin
    logic [1:0]    exp_rot [5];
    logic [DW-1:0] exp_rx  [5];
    exp_rot = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    arstn = 1'b0; req_valid = '0; req_len = '0; tv_en = '0; rsp_tready = '1; spur = 1'b0;
    base[0] = 8'h30; base[1] = 8'h40; base[2] = 8'hA1; base[3] = 8'h10;
    repeat (3) @(negedge clk);
    arstn = 1'b1;
    #1;
    check("rst_cs_n", 32'(cs_n), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_outs", 32'({req_tready, rsp_tvalid, eng_tx_tvalid}), 32'd0);
    check("idle_rx_ready", 32'(eng_rx_tready), 32'd1);

    // All four requesting, one word each: strict rotation from requester 0.
    req_len = '0; req_valid = '1; tv_en = '1;
    watch(5, 0, 0, 0, 0, 300);
    check("rot_acks", 32'(ack_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("rot_grant%0d", i), 32'(ack_log[i]), 32'(exp_rot[i]));
    exp_rx = '{8'hCF, 8'hBF, 8'h5E, 8'hEF, 8'hCF};
    check("rot_rx_count", 32'(rx_data.size()), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("rot_rx%0d", i), 32'(rx_data[i]), 32'(exp_rx[i]));
    check("rot_min_gap", 32'(min_run >= 5 && min_run < 999), 32'd1);

    // Requester 2, three words A1..A3 returned as 5E..5C.
    req_len = 32'h0002_0000; req_valid = 4'b0100;
    watch(1, 0, 0, 0, 0, 100);
    check("t1_grant", 32'(ack_log[0]), 32'd2);
    check("t1_cs_at_ack", 32'(cs_at_ack), 32'hB);
    check("t1_setup_len", 32'(t_tx - t_ack), 32'd2);
    exp_rx = '{8'h5E, 8'h5D, 8'h5C, 8'h00, 8'h00};
    check("t1_rx_count", 32'(rx_data.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_rx%0d", i), 32'(rx_data[i]), 32'(exp_rx[i]));
      check($sformatf("t1_last%0d", i), 32'(rx_last[i]), 32'(i == 2));
    end
    check("t1_cs_hold", 32'(t_cs - t_last), 32'd3);
    check("t1_idle_after_gap", 32'(t_idle - t_last), 32'd7);
    check("t1_grant_held", 32'(grant), 32'd2);

    // Requester 3 with rsp_tready low for 5 cycles mid-transfer.
    req_len = 32'h0200_0000; req_valid = 4'b1000;
    watch(1, 5, 5, 0, 0, 100);
    check("bp_rx_ready_low", 32'(stall_cyc), 32'd5);
    check("bp_tx_overlap", 32'(overlap), 32'd0);
    exp_rx = '{8'hEF, 8'hEE, 8'hED, 8'h00, 8'h00};
    check("bp_rx_count", 32'(rx_data.size()), 32'd3);
    for (int i = 0; i < 3; i++) check($sformatf("bp_rx%0d", i), 32'(rx_data[i]), 32'(exp_rx[i]));

    // Requester 0, four words, tx valid withheld for 10 cycles.
    req_len = 32'h0000_0003; req_valid = 4'b0001;
    watch(1, 0, 0, 6, 10, 150);
    check("gap_cs_rises", 32'(cs_rises), 32'd1);
    check("gap_rx_count", 32'(rx_data.size()), 32'd4);
    check("gap_rx3", 32'(rx_data[3]), 32'hCC);

    // Reset while requester 1 is stalled in XFER.
    req_len = 32'h0000_0300; tv_en = '0; req_valid = 4'b0010;
    repeat (4) @(negedge clk);
    req_valid = '0;
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_cs_n", 32'(cs_n), 32'hD);
    arstn = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_cs_n", 32'(cs_n), 32'hF);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rsp", 32'(rsp_tvalid), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    arstn = 1'b1; tv_en = '1; req_len = '0; req_valid = 4'b0011;
    watch(2, 0, 0, 0, 0, 100);
    check("post_rst_first", 32'(ack_log[0]), 32'd0);
    check("post_rst_second", 32'(ack_log[1]), 32'd1);
    check("post_rst_rx1", 32'(rx_data[1]), 32'hBF);

    // Spurious engine rx word while idle.
    check("spur_flag_clear", 32'(dut.spurious_seen), 32'd0);
    spur = 1'b1;
    #1;
    check("spur_rx_ready", 32'(eng_rx_tready), 32'd1);
    check("spur_no_rsp", 32'(rsp_tvalid), 32'd0);
    @(negedge clk);
    spur = 1'b0;
    #1;
    check("spur_flag_set", 32'(dut.spurious_seen), 32'd1);

    check("nongrant_quiet", 32'(nongrant_bad), 32'd0);
    check("ack_onehot", 32'(bad_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
